// File: rtl/pipeline_spi_pkg.sv
// Shared definitions for the SPI master and the pipeline_spi_control slave.
// Opcodes, payload packing, FSM state encoding and length clamping.
package pipeline_spi_pkg;

    localparam logic [7:0] OP_OVERLAY  = 8'h01;
    localparam logic [7:0] OP_SCALE    = 8'h02;
    localparam logic [7:0] OP_OFFSET_X = 8'h03;
    localparam logic [7:0] OP_OFFSET_Y = 8'h04;
    localparam logic [7:0] OP_CLIP_L   = 8'h05;
    localparam logic [7:0] OP_CLIP_R   = 8'h06;
    localparam logic [7:0] OP_CLIP_T   = 8'h07;
    localparam logic [7:0] OP_CLIP_B   = 8'h08;

    localparam int PAYLOAD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // Payload is 16 bits, right-justified; offsets are two's complement.
    function automatic logic [PAYLOAD_W-1:0] pack_payload(input int value);
        return PAYLOAD_W'(value);
    endfunction

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pipeline_spi_master_clkgen.sv
// sclk timing for the SPI master: counts half-periods while enabled and
// strobes the cycle before sclk rises, and the last high cycle (fall/sample).
module pipeline_spi_master_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic sample
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] cnt;
    logic          phase;
    logic          last;

    assign last   = en && (cnt == DW'(CLK_DIV - 1));
    assign rise   = last && !phase;
    assign fall   = last && phase;
    assign sample = fall;

    // Half-period counter; phase 0 = sclk low, phase 1 = sclk high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (last) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_spi_master.sv
// SPI mode-0 master: one command per SS frame, MSB first, MISO bits
// returned right-justified as a response word.
module pipeline_spi_master
    import pipeline_spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 3,
    parameter int SS_SETUP  = 2,
    parameter int SS_HOLD   = 2,
    parameter int GAP       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [MAX_BYTES*8-1:0]         cmd_data,
    input  logic [$clog2(MAX_BYTES+1)-1:0] cmd_len,
    output logic                           rsp_valid,
    output logic [MAX_BYTES*8-1:0]         rsp_data,
    output logic                           busy,
    output logic                           hw_spi_clk,
    output logic                           hw_spi_ss,
    output logic                           hw_spi_mosi,
    input  logic                           hw_spi_miso
);

    localparam int DW   = MAX_BYTES * 8;
    localparam int BW   = $clog2(MAX_BYTES * 8 + 1);
    localparam int TMAX = (SS_SETUP > SS_HOLD)
                        ? ((SS_SETUP > GAP) ? SS_SETUP : GAP)
                        : ((SS_HOLD > GAP) ? SS_HOLD : GAP);
    localparam int TW   = $clog2(TMAX + 1);

    spi_state_t    state;
    logic [DW-1:0] tx_sr;
    logic [DW-1:0] rx_sr;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] len_bits;
    logic [TW-1:0] tmr;
    logic          miso_s1;
    logic          miso_s2;
    logic          shift_en;
    logic          sck_rise;
    logic          sck_fall;
    logic          sck_sample;

    assign cmd_ready = (state == ST_IDLE);
    assign shift_en  = (state == ST_SHIFT);
    assign len_bits  = BW'(clamp_len(int'(cmd_len), MAX_BYTES) * 8);

    pipeline_spi_master_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .rise  (sck_rise),
        .fall  (sck_fall),
        .sample(sck_sample)
    );

    // Two-flop synchronizer for the asynchronous MISO line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= hw_spi_miso;
            miso_s2 <= miso_s1;
        end
    end

    // Frame sequencer with registered SPI pins and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hw_spi_ss   <= 1'b1;
            hw_spi_clk  <= 1'b0;
            hw_spi_mosi <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            busy        <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            tmr         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        busy    <= 1'b1;
                        tx_sr   <= cmd_data << 1;
                        rx_sr   <= '0;
                        bit_cnt <= len_bits;
                        if (len_bits == '0) begin
                            state <= ST_GAP;
                            tmr   <= '0;
                        end else begin
                            state       <= ST_SETUP;
                            tmr         <= TW'(SS_SETUP - 1);
                            hw_spi_ss   <= 1'b0;
                            hw_spi_mosi <= cmd_data[DW-1];
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr == '0) begin
                        state <= ST_SHIFT;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sck_sample) begin
                        rx_sr <= {rx_sr[DW-2:0], miso_s2};
                    end
                    if (sck_rise) begin
                        hw_spi_clk <= 1'b1;
                    end
                    if (sck_fall) begin
                        hw_spi_clk <= 1'b0;
                        if (bit_cnt == BW'(1)) begin
                            state   <= ST_HOLD;
                            tmr     <= TW'(SS_HOLD - 1);
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt     <= bit_cnt - 1'b1;
                            tx_sr       <= tx_sr << 1;
                            hw_spi_mosi <= tx_sr[DW-1];
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr == '0) begin
                        state       <= ST_GAP;
                        tmr         <= TW'(GAP - 1);
                        hw_spi_ss   <= 1'b1;
                        hw_spi_mosi <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= rx_sr;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_spi_master.sv
// Scoreboard bench for pipeline_spi_master: directed cases, then random
// commands against an async-skewed slave model.
`timescale 1ns/1ps
module tb_pipeline_spi_master;

    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 3;
    localparam int SS_SETUP  = 2;
    localparam int SS_HOLD   = 2;
    localparam int GAP       = 4;
    localparam int DW        = MAX_BYTES * 8;
    localparam int LW        = $clog2(MAX_BYTES + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic          hw_spi_clk;
    logic          hw_spi_ss;
    logic          hw_spi_mosi;
    logic          hw_spi_miso;

    logic          loop_mode = 1'b0;
    logic          slave_miso = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [23:0] mosi_bits;
        int          nbits;
        int          ss_width;
    } frame_t;

    frame_t      frame_q[$];
    logic [23:0] rsp_q[$];
    logic [23:0] slave_q[$];

    assign hw_spi_miso = loop_mode ? hw_spi_mosi : slave_miso;

    always #5 clk = ~clk;

    pipeline_spi_master #(
        .CLK_DIV  (CLK_DIV),
        .MAX_BYTES(MAX_BYTES),
        .SS_SETUP (SS_SETUP),
        .SS_HOLD  (SS_HOLD),
        .GAP      (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .hw_spi_clk (hw_spi_clk),
        .hw_spi_ss  (hw_spi_ss),
        .hw_spi_mosi(hw_spi_mosi),
        .hw_spi_miso(hw_spi_miso)
    );

    task automatic check_eq(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Slave: new word per frame, shifts out on sclk fall with skew < 1 clk.
    logic [23:0] sl_word = '0;
    int          sl_idx = 0;

    always @(negedge hw_spi_ss) begin
        if (slave_q.size() > 0) sl_word = slave_q.pop_front();
        else sl_word = '0;
        sl_idx = 0;
        #($urandom_range(1, 9));
        slave_miso = sl_word[23];
    end

    always @(negedge hw_spi_clk) begin
        if (hw_spi_ss === 1'b0) begin
            sl_idx++;
            if (sl_idx < 24) begin
                #($urandom_range(1, 9));
                slave_miso = sl_word[23 - sl_idx];
            end
        end
    end

    // Frame monitor: SS width, sclk pulses, MOSI bits, gap, idle levels.
    int          cyc = 0;
    bit          in_frame = 1'b0;
    int          ss_cnt = 0;
    int          pulses = 0;
    logic [23:0] mbits = '0;
    logic        prev_sclk = 1'b0;
    int          last_rise = -1;

    always @(negedge clk) begin
        frame_t f;
        cyc++;
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_sclk = 1'b0;
            last_rise = -1;
        end else begin
            check_eq("ready_vs_busy", cmd_ready, !busy);
            if (hw_spi_ss) begin
                check_eq("sclk_idle", hw_spi_clk, 0);
                check_eq("mosi_idle", hw_spi_mosi, 0);
                if (in_frame) begin
                    in_frame  = 1'b0;
                    last_rise = cyc;
                    check_eq("frame_expected", frame_q.size() > 0, 1);
                    if (frame_q.size() > 0) begin
                        f = frame_q.pop_front();
                        check_eq("ss_width", ss_cnt, f.ss_width);
                        check_eq("sclk_pulses", pulses, f.nbits);
                        check_eq("mosi_bits", mbits, f.mosi_bits);
                    end
                end
            end else begin
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    ss_cnt    = 0;
                    pulses    = 0;
                    mbits     = '0;
                    prev_sclk = 1'b0;
                    if (last_rise >= 0)
                        check_eq("ss_gap", (cyc - last_rise) >= GAP + 1, 1);
                end
                ss_cnt++;
                if (hw_spi_clk && !prev_sclk) begin
                    pulses++;
                    mbits = {mbits[22:0], hw_spi_mosi};
                end
                prev_sclk = hw_spi_clk;
            end
        end
    end

    // Response monitor: every rsp_valid pops one expectation.
    logic [23:0] last_rsp = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_rsp = '0;
        end else if (rsp_valid) begin
            check_eq("rsp_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0)
                check_eq("rsp_data", rsp_data, rsp_q.pop_front());
            last_rsp = rsp_data;
        end else begin
            check_eq("rsp_hold", rsp_data, last_rsp);
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [23:0] d, input int l,
                        input logic [23:0] sw, input bit keep);
        int     n = 0;
        int     lc;
        frame_t f;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_len   = LW'(l);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_in_time", n < 2000, 1);
        lc = (l > MAX_BYTES) ? MAX_BYTES : l;
        if (lc > 0) begin
            f.mosi_bits = d >> (24 - 8 * lc);
            f.nbits     = 8 * lc;
            f.ss_width  = SS_SETUP + 16 * CLK_DIV * lc + SS_HOLD;
            frame_q.push_back(f);
            rsp_q.push_back((loop_mode ? d : sw) >> (24 - 8 * lc));
            slave_q.push_back(sw);
        end
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rsp_q.size() > 0 || frame_q.size() > 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_in_time", n < 5000, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_ss", hw_spi_ss, 1);
        check_eq("rst_sclk", hw_spi_clk, 0);
        check_eq("rst_mosi", hw_spi_mosi, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rel_ready", cmd_ready, 1);
        @(negedge clk);

        loop_mode = 1'b1;
        send(24'hA50000, 1, 24'h0, 1'b0);
        wait_idle();
        send(24'h030FF0, 3, 24'h0, 1'b0);
        wait_idle();
        loop_mode = 1'b0;

        send(24'h3C0000, 1, 24'h3C0000, 1'b0);
        wait_idle();

        send(24'h123456, 2, 24'hC3A500, 1'b1);
        send(24'h9ABCDE, 3, 24'h5A5A5A, 1'b0);
        wait_idle();

        send(24'hFFFFFF, 0, 24'h0, 1'b0);
        check_eq("len0_ready_low", cmd_ready, 0);
        check_eq("len0_ss", hw_spi_ss, 1);
        @(negedge clk);
        check_eq("len0_ready_back", cmd_ready, 1);
        check_eq("len0_ss_after", hw_spi_ss, 1);
        repeat (10) @(negedge clk);

        send(24'hDEAD00, 2, 24'hBEEF00, 1'b0);
        repeat (SS_SETUP + 5 * 2 * CLK_DIV + 3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_ss", hw_spi_ss, 1);
        check_eq("midrst_sclk", hw_spi_clk, 0);
        check_eq("midrst_mosi", hw_spi_mosi, 0);
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_busy", busy, 0);
        frame_q.delete();
        rsp_q.delete();
        slave_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("midrst_ready", cmd_ready, 1);
        @(negedge clk);
        send(24'h5AC300, 2, 24'h81FF00, 1'b0);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            bit keep;
            keep = ($urandom_range(0, 3) == 0);
            send(DW'($urandom), int'($urandom_range(0, MAX_BYTES)),
                 DW'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check_eq("rsp_q_empty", rsp_q.size(), 0);
        check_eq("frame_q_empty", frame_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
